// File: rtl/iv_bus_ctrl.sv
// ---------------------------------------------------------------------------
// iv_bus_ctrl -- IV-bus controller for the S8x305 core.
//
// Decodes SC/WC bank cycles from the core, keeps one latched I/O address per
// bank (left/right), posts writes into a small FIFO and serves reads from a
// per-bank prefetched data register. All peripheral traffic goes through one
// ready/valid command port; queued writes always win over pending fetches.
//
// Optional feature macro: IVC_AUTO_INC_EN
//   defined   -> each WC cycle on a bank post-increments that bank's address
//   undefined -> a bank address changes only on SC
//
// Parameters
//   FIFO_DEPTH  posted-write FIFO entries (power of two, >= 2)
//   RESET_ADDR  reset value of both bank address registers
//
// Ports
//   clk        core oscillator clock
//   reset      asynchronous, active-low reset
//   mclk       core MCLK; its rising edge is the bus sample point
//   sc, wc     select-command / write-command (active high)
//   lb, rb     left / right bank enables (active low)
//   iv_in      IV pins in (pin = ~bitreverse(data))
//   iv_out     IV pin drive value, iv_oe its drive enable
//   cmd_*      peripheral command port (valid/ready, we, {bank,addr}, wdata)
//   rsp_valid  single-cycle read data strobe, rsp_data its data
//   ovf        sticky: a posted write was dropped on a full FIFO
//   busy       writes queued, or a fetch pending / in flight
// ---------------------------------------------------------------------------
module iv_bus_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] RESET_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mclk,
  input  logic       sc,
  input  logic       wc,
  input  logic       lb,
  input  logic       rb,
  input  logic [7:0] iv_in,
  output logic [7:0] iv_out,
  output logic       iv_oe,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_we,
  output logic [8:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic       ovf,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef IVC_AUTO_INC_EN
  localparam logic AUTO_INC = 1'b1;
`else
  localparam logic AUTO_INC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} state_t;

  typedef struct packed {
    logic       bank;   // 1 = right
    logic [7:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  // The IV pins carry data bit-reversed and inverted.
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Bus event decode
  // -------------------------------------------------------------------------
  logic       mclk_q;
  logic       bus_ev;
  logic [7:0] d;
  logic       sel_l, sel_r;
  logic       sc_l, sc_r, wc_l, wc_r, hit_l, hit_r;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mclk_q <= 1'b0;
    else        mclk_q <= mclk;
  end

  assign bus_ev = mclk & ~mclk_q;
  assign d      = ~bitrev8(iv_in);
  assign sel_l  = ~lb;
  assign sel_r  = ~rb;
  assign sc_l   = bus_ev & sc & sel_l;
  assign sc_r   = bus_ev & sc & sel_r;
  assign wc_l   = bus_ev & wc & sel_l;
  assign wc_r   = bus_ev & wc & sel_r;
  assign hit_l  = sc_l | wc_l;
  assign hit_r  = sc_r | wc_r;

  // -------------------------------------------------------------------------
  // Posted-write FIFO (up to two pushes per cycle when both banks selected)
  // -------------------------------------------------------------------------
  state_t          state, next_state;
  wr_entry_t       fifo_mem [FIFO_DEPTH];
  wr_entry_t       head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   free_slots;
  logic            pop, acc_l, acc_r, drop;
  logic [7:0]      addr_l, addr_r;

  assign pop        = (state == WR) & cmd_ready;
  // A pop in the same cycle frees its slot first, so a push at full fits.
  assign free_slots = (AW+2)'(FIFO_DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};
  assign acc_l      = wc_l & (free_slots != '0);
  // Left is pushed before right, so right needs one more free slot if left took one.
  assign acc_r      = wc_r & (free_slots > {{(AW+1){1'b0}}, acc_l});
  assign drop       = (wc_l & ~acc_l) | (wc_r & ~acc_r);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc_l) + AW'(acc_r);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(acc_l) + (AW+1)'(acc_r) - (AW+1)'(pop);
      if (drop) ovf <= 1'b1;
    end
  end

  // NOTE: the FIFO storage is not reset; the pointers and count define which
  // entries are live, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (acc_l) fifo_mem[wr_ptr] <= wr_entry_t'{bank: 1'b0, addr: addr_l, data: d};
    if (acc_r) fifo_mem[wr_ptr + AW'(acc_l)] <= wr_entry_t'{bank: 1'b1, addr: addr_r, data: d};
  end

  // -------------------------------------------------------------------------
  // Per-bank address, prefetch data, valid and pending flags
  // -------------------------------------------------------------------------
  logic [7:0] rd_l, rd_r;
  logic       valid_l, valid_r, pend_l, pend_r;
  logic       start_rd, start_bank;
  logic       cur_bank;
  logic [7:0] req_addr;
  logic       rsp_take;

  assign rsp_take = (state == RD_WAIT) & rsp_valid;

  // pend_b is dropped when the fetch is launched (address captured), so any
  // bus event on that bank from the launch cycle onwards re-arms pend_b and
  // keeps the returning data from being marked valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_l  <= RESET_ADDR;
      addr_r  <= RESET_ADDR;
      rd_l    <= 8'h00;
      rd_r    <= 8'h00;
      valid_l <= 1'b0;
      valid_r <= 1'b0;
      pend_l  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      if (sc_l)                 addr_l <= d;
      else if (wc_l && AUTO_INC) addr_l <= addr_l + 8'd1;
      if (sc_r)                 addr_r <= d;
      else if (wc_r && AUTO_INC) addr_r <= addr_r + 8'd1;

      if (rsp_take && !cur_bank) begin
        rd_l    <= rsp_data;
        valid_l <= ~pend_l;
      end
      if (rsp_take && cur_bank) begin
        rd_r    <= rsp_data;
        valid_r <= ~pend_r;
      end

      if (start_rd && !start_bank) pend_l <= 1'b0;
      if (start_rd &&  start_bank) pend_r <= 1'b0;

      // A bus event on the bank always wins: invalidate and refetch.
      if (hit_l) begin
        valid_l <= 1'b0;
        pend_l  <= 1'b1;
      end
      if (hit_r) begin
        valid_r <= 1'b0;
        pend_r  <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Peripheral port FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cur_bank <= 1'b0;
      req_addr <= 8'h00;
    end else begin
      state <= next_state;
      if (start_rd) begin
        cur_bank <= start_bank;
        req_addr <= start_bank ? addr_r : addr_l;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    start_rd   = 1'b0;
    start_bank = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = 9'h000;
    cmd_wdata  = 8'h00;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = WR;
        end else if (pend_l) begin
          next_state = RD_REQ;
          start_rd   = 1'b1;
        end else if (pend_r) begin
          next_state = RD_REQ;
          start_rd   = 1'b1;
          start_bank = 1'b1;
        end
      end
      WR: begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = {head.bank, head.addr};
        cmd_wdata = head.data;
        if (cmd_ready) next_state = IDLE;
      end
      RD_REQ: begin
        cmd_valid = 1'b1;
        cmd_addr  = {cur_bank, req_addr};
        if (cmd_ready) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (rsp_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (count != '0) | pend_l | pend_r | (state != IDLE);

  // -------------------------------------------------------------------------
  // Read drive onto the IV pins
  // -------------------------------------------------------------------------
  logic [7:0] rd_sel;

  assign rd_sel = sel_l ? (valid_l ? rd_l : 8'hFF) : (valid_r ? rd_r : 8'hFF);
  assign iv_out = ~bitrev8(rd_sel);
  assign iv_oe  = (sel_l ^ sel_r) & ~sc & ~wc;

endmodule

// File: tb/tb_iv_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iv_bus_ctrl -- self-checking bench for iv_bus_ctrl.
// A peripheral memory model answers commands; a transaction-level model of
// bank addresses, accepted writes and memory contents predicts read-back
// values and the ordered list of peripheral writes.
// ---------------------------------------------------------------------------
module tb_iv_bus_ctrl;

  localparam int         DEPTH  = 4;
  localparam logic [7:0] RST_A  = 8'h00;
  localparam int         BIGBUD = 1 << 30;

  logic       clk = 1'b0, reset = 1'b0, mclk = 1'b0;
  logic       sc = 1'b0, wc = 1'b0, lb = 1'b1, rb = 1'b1;
  logic [7:0] iv_in = 8'h00;
  logic [7:0] iv_out;
  logic       iv_oe;
  logic       cmd_valid, cmd_we;
  logic       cmd_ready = 1'b0;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       ovf, busy;

  iv_bus_ctrl #(.FIFO_DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .reset(reset), .mclk(mclk), .sc(sc), .wc(wc), .lb(lb), .rb(rb),
    .iv_in(iv_in), .iv_out(iv_out), .iv_oe(iv_oe),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         we;
    logic [8:0] addr;
    logic [7:0] data;
  } cmd_t;

  int total = 0;
  int bad   = 0;

  // Peripheral model state
  logic [7:0] pmem [512];
  cmd_t       log_q[$];
  bit         ready_en = 1'b0, ready_rand = 1'b0;
  int         rsp_fixed = 0, rsp_cnt = 0, rsp_seen = 0;
  logic [8:0] rsp_addr = 9'h000;

  // Reference model state
  logic [7:0] exp_mem [512];
  logic [7:0] addr_m [2];
  bit         touched [2];
  cmd_t       exp_wr[$];
  int         accept_budget = BIGBUD;

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] pins_of(input logic [7:0] v);
    return ~bitrev(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Peripheral: random or steady ready, memory-backed reads after a delay.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rsp_cnt   = 0;
      rsp_valid = 1'b0;
      cmd_ready = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = pmem[rsp_addr];
          rsp_seen++;
        end
      end
      cmd_ready = ready_en && (!ready_rand || ($urandom_range(0, 1) == 1));
      if (cmd_valid && cmd_ready) begin
        log_q.push_back('{cmd_we, cmd_addr, cmd_wdata});
        if (cmd_we) begin
          pmem[cmd_addr] = cmd_wdata;
        end else begin
          rsp_addr = cmd_addr;
          rsp_cnt  = (rsp_fixed > 0) ? rsp_fixed : int'($urandom_range(1, 4));
        end
      end
    end
  end

  task automatic model_reset();
    addr_m[0]  = RST_A;
    addr_m[1]  = RST_A;
    touched[0] = 1'b0;
    touched[1] = 1'b0;
    exp_wr.delete();
    log_q.delete();
  endtask

  // One core bus cycle; the model is updated from the same rules.
  task automatic bus_op(input bit do_sc, input bit do_wc, input bit sl, input bit sr,
                        input logic [7:0] dv);
    bit sel [2];
    sel[0] = sl;
    sel[1] = sr;
    @(negedge clk);
    lb = ~sl; rb = ~sr; sc = do_sc; wc = do_wc; iv_in = pins_of(dv); mclk = 1'b1;
    @(negedge clk);
    mclk = 1'b0; sc = 1'b0; wc = 1'b0; lb = 1'b1; rb = 1'b1; iv_in = 8'h00;
    for (int b = 0; b < 2; b++) begin
      if (sel[b]) begin
        logic bb;
        bb = b[0];
        touched[b] = 1'b1;
        if (do_sc) addr_m[b] = dv;
        if (do_wc) begin
          if (accept_budget > 0) begin
            exp_wr.push_back('{1'b1, {bb, addr_m[b]}, dv});
            exp_mem[{bb, addr_m[b]}] = dv;
            accept_budget--;
          end
`ifdef IVC_AUTO_INC_EN
          addr_m[b] = addr_m[b] + 8'd1;
`endif
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic read_bank(input string tag, input bit b);
    logic [7:0] ev;
    logic       bb;
    bb = b;
    ev = touched[b] ? exp_mem[{bb, addr_m[b]}] : 8'hFF;
    lb = b; rb = ~b;
    #1;
    check({tag, "_oe"}, iv_oe, 1'b1);
    check({tag, "_pins"}, iv_out, pins_of(ev));
    lb = 1'b1; rb = 1'b1;
  endtask

  task automatic compare_writes(input string tag);
    cmd_t w[$];
    foreach (log_q[i]) if (log_q[i].we) w.push_back(log_q[i]);
    check({tag, "_nwr"}, w.size(), exp_wr.size());
    for (int i = 0; i < w.size() && i < exp_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {w[i].addr, w[i].data},
            {exp_wr[i].addr, exp_wr[i].data});
  endtask

  initial begin
    int n;
    int seen0;
    for (int i = 0; i < 512; i++) begin
      pmem[i]    = 8'($urandom);
      exp_mem[i] = pmem[i];
    end
    model_reset();

    // Reset state
    #1;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    read_bank("rst_l", 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Select and read: SC on L with 3A, peripheral returns C5
    pmem[9'h03A] = 8'hC5; exp_mem[9'h03A] = 8'hC5;
    ready_en = 1'b0;
    bus_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h3A);
    check("sc_lat_n1", cmd_valid, 1'b0);
    @(negedge clk);
    check("sc_lat_n2", cmd_valid, 1'b1);
    check("sc_rd_we", cmd_we, 1'b0);
    check("sc_rd_addr", cmd_addr, 9'h03A);
    ready_en = 1'b1;
    wait_idle("sc", 50);
    read_bank("sc_l", 1'b0);
    lb = 1'b0; #1;
    check("sc_l_5c", iv_out, 8'h5C);
    lb = 1'b1;
    check("sc_nlog", log_q.size(), 1);

    // Write ordering: write {1,10,77} precedes the refresh read
    bus_op(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    wait_idle("wo_sc", 50);
    log_q.delete(); exp_wr.delete();
    ready_en = 1'b0;
    bus_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    check("wc_lat_n1", cmd_valid, 1'b0);
    @(negedge clk);
    check("wc_lat_n2", cmd_valid, 1'b1);
    check("wc_we", cmd_we, 1'b1);
    check("wc_addr", cmd_addr, 9'h110);
    check("wc_data", cmd_wdata, 8'h77);
    ready_en = 1'b1;
    wait_idle("wo", 50);
    check("wo_nlog", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("wo_first_we", log_q[0].we, 1'b1);
      check("wo_second_rd", {log_q[1].we, log_q[1].addr}, {1'b0, 1'b1, addr_m[1]});
    end
    compare_writes("wo");
    read_bank("wo_r", 1'b1);

    // Overflow: DEPTH+1 writes with cmd_ready low
    log_q.delete(); exp_wr.delete();
    ready_en = 1'b0;
    accept_budget = DEPTH;
    for (int i = 0; i <= DEPTH; i++) bus_op(1'b0, 1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
    accept_budget = BIGBUD;
    check("ovf_set", ovf, 1'b1);
    check("ovf_busy", busy, 1'b1);
    ready_en = 1'b1;
    wait_idle("ovf", 100);
    compare_writes("ovf");
    check("ovf_sticky", ovf, 1'b1);
    read_bank("ovf_l", 1'b0);

    // Stale fetch: second SC while the first read is outstanding
    log_q.delete(); exp_wr.delete();
    pmem[9'h001] = 8'h11; exp_mem[9'h001] = 8'h11;
    pmem[9'h002] = 8'h22; exp_mem[9'h002] = 8'h22;
    rsp_fixed = 6;
    seen0 = rsp_seen;
    bus_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
    n = 0;
    while (log_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
    check("stale_first_req", log_q.size(), 1);
    bus_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
    n = 0;
    while (rsp_seen == seen0 && n < 20) begin @(negedge clk); n++; end
    check("stale_first_rsp", rsp_seen, seen0 + 1);
    repeat (2) @(negedge clk);
    lb = 1'b0; #1;
    check("stale_not_valid", iv_out, 8'h00);
    lb = 1'b1;
    wait_idle("stale", 60);
    check("stale_nlog", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("stale_rd0", {log_q[0].we, log_q[0].addr}, 10'h001);
      check("stale_rd1", {log_q[1].we, log_q[1].addr}, 10'h002);
    end
    read_bank("stale_l", 1'b0);
    rsp_fixed = 0;

    // Address wrap across two WC events after SC FF
    log_q.delete(); exp_wr.delete();
    bus_op(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    bus_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    bus_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h5B);
    wait_idle("inc", 80);
    compare_writes("inc");
    begin
      cmd_t w[$];
      foreach (log_q[i]) if (log_q[i].we) w.push_back(log_q[i]);
      if (w.size() == 2) begin
        check("inc_addr0", w[0].addr, 9'h0FF);
`ifdef IVC_AUTO_INC_EN
        check("inc_addr1", w[1].addr, 9'h000);
`else
        check("inc_addr1", w[1].addr, 9'h0FF);
`endif
      end
    end
    read_bank("inc_l", 1'b0);

    // Reset during RD_REQ
    ready_en = 1'b0;
    bus_op(1'b1, 1'b0, 1'b0, 1'b1, 8'h44);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("mid_in_req", cmd_valid, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_cmd_valid", cmd_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_ovf", ovf, 1'b0);
    model_reset();
    read_bank("mid_r", 1'b1);
    read_bank("mid_l", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    ready_en = 1'b1;
    bus_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
    wait_idle("mid", 50);
    compare_writes("mid");
    begin
      cmd_t w[$];
      foreach (log_q[i]) if (log_q[i].we) w.push_back(log_q[i]);
      if (w.size() == 1) check("mid_reset_addr", w[0].addr, {1'b0, RST_A});
    end
    read_bank("mid_l2", 1'b0);
    read_bank("mid_r2", 1'b1);

    // Randomized bus traffic against the model
    log_q.delete(); exp_wr.delete();
    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit         k;
      int         bs;
      logic [7:0] dv;
      k  = 1'($urandom_range(0, 1));
      bs = int'($urandom_range(1, 3));
      dv = 8'($urandom);
      bus_op(k, ~k, bs[0], bs[1], dv);
      wait_idle($sformatf("rnd%0d", i), 300);
      check($sformatf("rnd%0d_ovf", i), ovf, 1'b0);
      read_bank($sformatf("rnd%0d_l", i), 1'b0);
      read_bank($sformatf("rnd%0d_r", i), 1'b1);
    end
    compare_writes("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
